mem_arbiter: RTL

//   Shares one 128-bit line-wide memory port between the instruction cache (I, read-only)
//   and the data cache (D, read + write-back). Grants one whole transaction at a time.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D caches, the arbiter and the shared line-wide memory port.
// master: arbiter view; slave: caches + memory environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
           mem_rdata, mem_ready,
    output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
           mem_rdata, mem_ready,
    input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Whole-transaction arbiter sharing one memory port between I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed D-priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              last_grant_q, last_grant_d;

  logic req_i;
  logic req_d;
  logic tie_to_d;
  logic pick_d;

  assign req_i = bus.i_mem_read;
  assign req_d = bus.d_mem_read | bus.d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_d = ~last_grant_q;
`else
  assign tie_to_d = 1'b1;
`endif

  assign pick_d = req_d & (~req_i | tie_to_d);

  always_comb begin
    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          // A write-back wins over a simultaneous read from the same D request.
          mem_read_d   = bus.d_mem_read & ~bus.d_mem_write;
          mem_write_d  = bus.d_mem_write;
          mem_addr_d   = bus.d_mem_addr;
          mem_wdata_d  = bus.d_mem_wdata;
          last_grant_d = 1'b1;
          state_d      = BUSY_D;
        end else if (req_i) begin
          mem_read_d   = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = bus.i_mem_addr;
          last_grant_d = 1'b0;
          state_d      = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DRAIN;
        end
      end
      // One dead cycle lets the owner drop its request after its registered ready.
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_mem_ready = bus.mem_ready & (state_q == BUSY_I);
  assign bus.d_mem_ready = bus.mem_ready & (state_q == BUSY_D);
  assign bus.i_mem_rdata = bus.mem_rdata;
  assign bus.d_mem_rdata = bus.mem_rdata;

endmodule
